spi_blkread_ctrl: RTL
=====================

Name: spi_blkread_ctrl

Overview:
Sequences the SPI microSD datapath to read one 512-byte block after card initialisation has finished. It issues CMD17 and polls R1, then polls for the start token, streams the data bytes out, and consumes the CRC bytes. It sits between the bootstrap loader, which issues requests, and the SPI transfer core, which it drives through command/statusreg/start and sees through the flag register. It owns the core only while it is busy.

Parameters:
BLOCK_BYTES, 512, data bytes per block. Sets the width of the byte index.
R1_RETRIES, 8, maximum 0xFF poll bytes while waiting for R1.
TOKEN_TIMEOUT, 4096, maximum 0xFF poll bytes while waiting for the start token.
START_TOKEN, 8'hFE, single-block data start token.

Ports:
spi_clk_i  in  1  master clock
spi_rst_i  in  1  master reset; synchronous, active-high
spi_initdone_i  in  1  card initialisation complete
rd_req_i  in  1  read request, sampled only in IDLE
rd_addr_i  in  32  block address, captured with rd_req_i
rd_busy_o  out  1  sequence in progress
rd_done_o  out  1  one-cycle pulse, block read OK
rd_err_o  out  1  one-cycle pulse, block read failed
rd_errcode_o  out  3  error cause, held until the next accepted request
spi_cmd_o  out  48  command word to the SPI core
spi_statusreg_o  out  9  statusreg to the SPI core
spi_start_o  out  1  one-cycle pulse, launch one core transaction
spi_flagreg_i  in  3  [0] WORD_COM, [1] OPERT_DONE, [2] DATA_WR
spi_rxbyte_i  in  8  received byte, valid when OPERT_DONE=1
byte_o  out  8  data byte out
byte_valid_o  out  1  one-cycle strobe for byte_o
byte_idx_o  out  9  index of byte_o, 0..BLOCK_BYTES-1

Behaviour:
- Reset values: spi_cmd_o=48'hFFFFFFFFFFFF; all other outputs 0; state IDLE; counters 0.
- Two core transaction types, each launched by a one-cycle spi_start_o and finished when spi_flagreg_i[1]=1 for one cycle:
  - CMD: spi_cmd_o={2'b01,6'd17,addr,8'h01}, statusreg=9'b101000101; spi_rxbyte_i returns the first response byte.
  - BYTE: spi_cmd_o=48'hFFFFFFFFFFFF, statusreg=9'b101010101; one byte is clocked in.
- spi_cmd_o and spi_statusreg_o are held stable from spi_start_o until OPERT_DONE.
- States and transitions:
  - IDLE: if rd_req_i && spi_initdone_i, capture the address, clear rd_errcode_o, go to CMD. A request with spi_initdone_i=0 is ignored silently.
  - CMD: pulse start (CMD), then CMD_W.
  - CMD_W: on OPERT_DONE, evaluate the byte:
    - 0xFF: poll count < R1_RETRIES -> R1P (BYTE), else ERR code 1.
    - 0x00: go to TOK.
    - any other value: ERR code 1.
  - R1P: pulse start (BYTE), increment the poll count, wait for OPERT_DONE, apply the same evaluation as CMD_W.
  - TOK: pulse start (BYTE), wait for OPERT_DONE, then:
    - START_TOKEN: go to DATA.
    - 0xFF: increment the token count; reaching TOKEN_TIMEOUT -> ERR code 2.
    - 8'b0000xxxx: data error token, ERR code 3.
    - any other value: keep polling; it counts toward the timeout.
  - DATA: BYTE transaction per byte. On OPERT_DONE, byte_o=rx, byte_valid_o=1 for one cycle, byte_idx_o=count. After index BLOCK_BYTES-1 go to CRC.
  - CRC: two BYTE transactions, then DONE.
  - DONE: rd_done_o pulse, back to IDLE.
  - ERR: rd_err_o pulse, rd_errcode_o latched, back to IDLE.
- Minimum spacing between consecutive spi_start_o pulses is 1 idle cycle after OPERT_DONE.
- rd_busy_o=1 in every state except IDLE. rd_req_i is ignored while busy. DONE/ERR take one cycle, so a request held high is accepted on the cycle after the pulse.
- OPERT_DONE arriving in a state not waiting for it is ignored. WORD_COM and DATA_WR are ignored.
- Reset asserted mid-sequence aborts at the next clock edge: no done/err pulse, outputs go to reset values. The core is not drained.
- Counters saturate and never wrap. The byte index is 9 bits and wraps only through the state change.

Optional Feature:
SPI_BLKRD_CRC_EN:
- Defined: a CRC16-CCITT (poly 0x1021, init 0x0000) is computed over the data bytes as they arrive. It is compared with the two CRC bytes, MSB first. A mismatch goes to ERR with code 4 instead of DONE.
- Undefined: the CRC bytes are clocked and discarded, and code 4 is never produced.

Test Plan:
- Happy path: addr=0x00000010, R1=0x00, two 0xFF bytes then 0xFE, data i&0xFF, CRC bytes -> spi_cmd_o=0x5100000010 01; 512 strobes with byte_idx 0..511; rd_done_o pulse; 0 errors.
- R1 poll: CMD returns 0xFF three times, then 0x00 -> 3 R1P transactions, read completes. Same test with 9 0xFF bytes -> rd_err_o, code 1.
- Token timeout: R1=0x00, then 0xFF forever -> exactly 4096 BYTE transactions in TOK, then rd_err_o, code 2.
- Error token 0x08 after R1 -> ERR code 3, no byte_valid_o. Request with spi_initdone_i=0 -> no spi_start_o, rd_busy_o stays 0.
- Reset at data byte 100 -> next cycle all outputs at reset values, no done/err pulse. A following request completes normally.
- SPI_BLKRD_CRC_EN: all-zero data with CRC 0x0000 -> done; the same data with CRC 0x1234 -> ERR code 4. Macro undefined: the same stimulus -> done.

Source files
------------

// File: rtl/spi_blkread_ctrl.sv
// Single-block (CMD17) microSD read sequencer driving the SPI transfer core.
// Optional CRC16 check of the data block: define SPI_BLKRD_CRC_EN.
module spi_blkread_ctrl #(
    parameter int unsigned BLOCK_BYTES   = 512,
    parameter int unsigned R1_RETRIES    = 8,
    parameter int unsigned TOKEN_TIMEOUT = 4096,
    parameter logic [7:0]  START_TOKEN   = 8'hFE,
    localparam int unsigned IDX_W        = $clog2(BLOCK_BYTES)
) (
    input  logic             spi_clk_i,
    input  logic             spi_rst_i,
    input  logic             spi_initdone_i,
    input  logic             rd_req_i,
    input  logic [31:0]      rd_addr_i,
    output logic             rd_busy_o,
    output logic             rd_done_o,
    output logic             rd_err_o,
    output logic [2:0]       rd_errcode_o,
    output logic [47:0]      spi_cmd_o,
    output logic [8:0]       spi_statusreg_o,
    output logic             spi_start_o,
    input  logic [2:0]       spi_flagreg_i,
    input  logic [7:0]       spi_rxbyte_i,
    output logic [7:0]       byte_o,
    output logic             byte_valid_o,
    output logic [IDX_W-1:0] byte_idx_o
);

    localparam int unsigned R1_W  = $clog2(R1_RETRIES + 1);
    localparam int unsigned TOK_W = $clog2(TOKEN_TIMEOUT + 1);

    localparam logic [47:0] CMD_IDLE = 48'hFFFF_FFFF_FFFF;
    localparam logic [8:0]  ST_CMD   = 9'b101000101;
    localparam logic [8:0]  ST_BYTE  = 9'b101010101;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CMD   = 4'd1;
    localparam logic [3:0] S_CMD_W = 4'd2;
    localparam logic [3:0] S_R1P   = 4'd3;
    localparam logic [3:0] S_R1P_W = 4'd4;
    localparam logic [3:0] S_TOK   = 4'd5;
    localparam logic [3:0] S_TOK_W = 4'd6;
    localparam logic [3:0] S_DATA  = 4'd7;
    localparam logic [3:0] S_DAT_W = 4'd8;
    localparam logic [3:0] S_CRC   = 4'd9;
    localparam logic [3:0] S_CRC_W = 4'd10;
    localparam logic [3:0] S_DONE  = 4'd11;
    localparam logic [3:0] S_ERR   = 4'd12;

    logic [3:0]       r_state,     w_state;
    logic [31:0]      r_addr,      w_addr;
    logic [R1_W-1:0]  r_r1_cnt,    w_r1_cnt;
    logic [TOK_W-1:0] r_tok_cnt,   w_tok_cnt;
    logic [IDX_W-1:0] r_idx,       w_idx;
    logic             r_crc_sel,   w_crc_sel;
    logic [15:0]      r_crc_calc,  w_crc_calc;
    logic [7:0]       r_crc_hi,    w_crc_hi;
    logic             r_busy,      w_busy;
    logic             r_done,      w_done;
    logic             r_err,       w_err;
    logic [2:0]       r_errcode,   w_errcode;
    logic [47:0]      r_cmd,       w_cmd;
    logic [8:0]       r_status,    w_status;
    logic             r_start,     w_start;
    logic [7:0]       r_byte,      w_byte;
    logic             r_byte_vld,  w_byte_vld;
    logic [IDX_W-1:0] r_byte_idx,  w_byte_idx;

    logic w_op_done;
    logic w_unused_flags;

    assign w_op_done      = spi_flagreg_i[1];
    assign w_unused_flags = spi_flagreg_i[0] ^ spi_flagreg_i[2];

    // CRC16-CCITT (poly 0x1021), one byte MSB first
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_r1_cnt   = r_r1_cnt;
        w_tok_cnt  = r_tok_cnt;
        w_idx      = r_idx;
        w_crc_sel  = r_crc_sel;
        w_crc_calc = r_crc_calc;
        w_crc_hi   = r_crc_hi;
        w_errcode  = r_errcode;
        w_cmd      = r_cmd;
        w_status   = r_status;
        w_byte     = r_byte;
        w_byte_idx = r_byte_idx;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_start    = 1'b0;
        w_byte_vld = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (rd_req_i && spi_initdone_i) begin
                    w_addr     = rd_addr_i;
                    w_errcode  = 3'd0;
                    w_r1_cnt   = '0;
                    w_tok_cnt  = '0;
                    w_idx      = '0;
                    w_crc_sel  = 1'b0;
                    w_crc_calc = 16'h0000;
                    w_state    = S_CMD;
                end
            end
            S_CMD: begin
                w_start  = 1'b1;
                w_cmd    = {2'b01, 6'd17, r_addr, 8'h01};
                w_status = ST_CMD;
                w_state  = S_CMD_W;
            end
            S_CMD_W, S_R1P_W: begin
                if (w_op_done) begin
                    if (spi_rxbyte_i == 8'hFF && r_r1_cnt < R1_W'(R1_RETRIES)) begin
                        w_state = S_R1P;
                    end else if (spi_rxbyte_i == 8'h00) begin
                        w_state = S_TOK;
                    end else begin
                        w_err     = 1'b1;
                        w_errcode = 3'd1;
                        w_state   = S_ERR;
                    end
                end
            end
            S_R1P: begin
                w_start  = 1'b1;
                w_cmd    = CMD_IDLE;
                w_status = ST_BYTE;
                if (r_r1_cnt != '1) w_r1_cnt = r_r1_cnt + R1_W'(1);
                w_state  = S_R1P_W;
            end
            S_TOK: begin
                w_start  = 1'b1;
                w_cmd    = CMD_IDLE;
                w_status = ST_BYTE;
                w_state  = S_TOK_W;
            end
            S_TOK_W: begin
                if (w_op_done) begin
                    if (spi_rxbyte_i == START_TOKEN) begin
                        w_state = S_DATA;
                    end else if (spi_rxbyte_i[7:4] == 4'h0) begin
                        w_err     = 1'b1;
                        w_errcode = 3'd3;
                        w_state   = S_ERR;
                    end else if (r_tok_cnt >= TOK_W'(TOKEN_TIMEOUT - 1)) begin
                        w_tok_cnt = TOK_W'(TOKEN_TIMEOUT);
                        w_err     = 1'b1;
                        w_errcode = 3'd2;
                        w_state   = S_ERR;
                    end else begin
                        w_tok_cnt = r_tok_cnt + TOK_W'(1);
                        w_state   = S_TOK;
                    end
                end
            end
            S_DATA, S_CRC: begin
                w_start  = 1'b1;
                w_cmd    = CMD_IDLE;
                w_status = ST_BYTE;
                w_state  = (r_state == S_DATA) ? S_DAT_W : S_CRC_W;
            end
            S_DAT_W: begin
                if (w_op_done) begin
                    w_byte     = spi_rxbyte_i;
                    w_byte_vld = 1'b1;
                    w_byte_idx = r_idx;
                    w_crc_calc = crc_step(r_crc_calc, spi_rxbyte_i);
                    if (r_idx == IDX_W'(BLOCK_BYTES - 1)) begin
                        w_state = S_CRC;
                    end else begin
                        w_idx   = r_idx + IDX_W'(1);
                        w_state = S_DATA;
                    end
                end
            end
            S_CRC_W: begin
                if (w_op_done) begin
                    if (!r_crc_sel) begin
                        w_crc_sel = 1'b1;
                        w_crc_hi  = spi_rxbyte_i;
                        w_state   = S_CRC;
                    end else begin
`ifdef SPI_BLKRD_CRC_EN
                        if ({r_crc_hi, spi_rxbyte_i} != r_crc_calc) begin
                            w_err     = 1'b1;
                            w_errcode = 3'd4;
                            w_state   = S_ERR;
                        end else begin
                            w_done  = 1'b1;
                            w_state = S_DONE;
                        end
`else
                        w_done  = 1'b1;
                        w_state = S_DONE;
`endif
                    end
                end
            end
            S_DONE, S_ERR: begin
                // release the core interface back to its idle values
                w_cmd    = CMD_IDLE;
                w_status = 9'd0;
                w_state  = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge spi_clk_i) begin
        if (spi_rst_i) begin
            r_state    <= S_IDLE;
            r_addr     <= 32'd0;
            r_r1_cnt   <= '0;
            r_tok_cnt  <= '0;
            r_idx      <= '0;
            r_crc_sel  <= 1'b0;
            r_crc_calc <= 16'h0000;
            r_crc_hi   <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_errcode  <= 3'd0;
            r_cmd      <= CMD_IDLE;
            r_status   <= 9'd0;
            r_start    <= 1'b0;
            r_byte     <= 8'h00;
            r_byte_vld <= 1'b0;
            r_byte_idx <= '0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_r1_cnt   <= w_r1_cnt;
            r_tok_cnt  <= w_tok_cnt;
            r_idx      <= w_idx;
            r_crc_sel  <= w_crc_sel;
            r_crc_calc <= w_crc_calc;
            r_crc_hi   <= w_crc_hi;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
            r_errcode  <= w_errcode;
            r_cmd      <= w_cmd;
            r_status   <= w_status;
            r_start    <= w_start;
            r_byte     <= w_byte;
            r_byte_vld <= w_byte_vld;
            r_byte_idx <= w_byte_idx;
        end
    end

    assign rd_busy_o       = r_busy;
    assign rd_done_o       = r_done;
    assign rd_err_o        = r_err;
    assign rd_errcode_o    = r_errcode;
    assign spi_cmd_o       = r_cmd;
    assign spi_statusreg_o = r_status;
    assign spi_start_o     = r_start;
    assign byte_o          = r_byte;
    assign byte_valid_o    = r_byte_vld;
    assign byte_idx_o      = r_byte_idx;

endmodule
